// File: rtl/rv32v_hazard_pkg.sv
// Shared types and helpers for the RV32V hazard unit.
// Optional feature macro used by this slice: RV32V_HAZARD_PERF_EN.
package rv32v_hazard_pkg;

    localparam int NUM_VSTAGES = 5;

    // CSR update sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } hazard_state_t;

    // Pipeline stage positions, youngest (F1) to oldest (MEM).
    typedef enum logic [2:0] {
        ST_F1  = 3'd0,
        ST_F2  = 3'd1,
        ST_DEC = 3'd2,
        ST_EX  = 3'd3,
        ST_MEM = 3'd4
    } stage_idx_t;

    typedef logic [NUM_VSTAGES-1:0] stage_vec_t;

    typedef struct packed {
        stage_vec_t stall;
        stage_vec_t flush;
    } stage_ctl_t;

    // Busy back-pressure: a busy stage stalls itself and every younger stage,
    // and the stage just older than the oldest stalled one takes a bubble.
    function automatic stage_ctl_t stall_chain(input stage_vec_t busy);
        stage_ctl_t r;
        logic       any_older;
        r         = '0;
        any_older = 1'b0;
        for (int s = NUM_VSTAGES - 1; s >= 0; s--) begin
            any_older  = any_older | busy[s];
            r.stall[s] = any_older;
        end
        for (int s = 1; s < NUM_VSTAGES; s++) begin
            r.flush[s] = r.stall[s-1] & ~r.stall[s];
        end
        return r;
    endfunction

endpackage

// File: rtl/rv32v_hazard_unit_if.sv
// Stall/flush bundle between the hazard unit and the five pipeline stages.
// Optional feature macro used by this slice: RV32V_HAZARD_PERF_EN (not used here).
//
// Signalling: every signal is a level, evaluated each cycle; there is no
// valid/ready handshake. A stage raises busy while it cannot advance and must
// obey its stall/flush in the same cycle; busy must never depend on the
// stage's own stall.
interface rv32v_hazard_unit_if;

    logic busy_f1;
    logic busy_f2;
    logic busy_dec;
    logic busy_ex;
    logic busy_mem;
    logic csr_update;
    logic exception_mem;

    logic stall_f1, flush_f1;
    logic stall_f2, flush_f2;
    logic stall_dec, flush_dec;
    logic stall_ex, flush_ex;
    logic stall_mem, flush_mem;

    modport hazard_unit (
        input  busy_dec, busy_ex, busy_mem, csr_update,
        output stall_f1, flush_f1, stall_f2, flush_f2, stall_dec, flush_dec,
        output stall_ex, flush_ex, stall_mem, flush_mem
    );

    modport flush1 (
        output busy_f1,
        input  stall_f1, flush_f1
    );

    modport flush2 (
        output busy_f2,
        input  stall_f2, flush_f2
    );

    modport decode (
        output busy_dec,
        input  stall_dec, flush_dec
    );

    modport execute (
        output busy_ex,
        input  stall_ex, flush_ex
    );

    modport memory (
        output busy_mem, csr_update, exception_mem,
        input  stall_mem, flush_mem
    );

endinterface

// File: rtl/rv32v_hazard_perf_cnt.sv
// Saturating stall-cycle counter; only instantiated when RV32V_HAZARD_PERF_EN is defined.
module rv32v_hazard_perf_cnt #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count qualifying cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rv32v_hazard_unit.sv
// Central stall/flush controller for the RV32V 5-stage vector pipeline.
// Combines the busy back-pressure chain, MEM exceptions and a vset* CSR
// FLUSH -> HOLD -> IDLE sequence into per-stage stall/flush.
// Optional feature macro: RV32V_HAZARD_PERF_EN adds the stall_cycles counter.
module rv32v_hazard_unit
    import rv32v_hazard_pkg::*;
#(
    parameter int CSR_HOLD_CYCLES = 2
`ifdef RV32V_HAZARD_PERF_EN
    ,
    parameter int PERF_CNT_W      = 32
`endif
) (
    input  logic                        CLK,
    input  logic                        RST,
    rv32v_hazard_unit_if.hazard_unit    hu_if,
    input  logic                        busy_f1,
    input  logic                        busy_f2,
    input  logic                        exception_mem,
    output hazard_state_t               dbg_state
`ifdef RV32V_HAZARD_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]       stall_cycles
`endif
);

    localparam logic [3:0] HOLD_LOAD = 4'(CSR_HOLD_CYCLES - 1);

    hazard_state_t state, state_next;
    logic [3:0]    hold_cnt, hold_next;
    stage_vec_t    busy_v;
    stage_ctl_t    chain;
    stage_vec_t    stall_v, flush_v;

    assign busy_v    = {hu_if.busy_mem, hu_if.busy_ex, hu_if.busy_dec, busy_f2, busy_f1};
    assign chain     = stall_chain(busy_v);
    assign dbg_state = state;

    // Sequencer state and hold counter register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
        end
    end

    // Next-state: an exception aborts any sequence; a CSR update (re)starts one.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        if (exception_mem) begin
            state_next = IDLE;
            hold_next  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hu_if.csr_update) begin
                        state_next = FLUSH;
                    end
                end
                FLUSH: begin
                    state_next = HOLD;
                    hold_next  = HOLD_LOAD;
                end
                HOLD: begin
                    if (hu_if.csr_update) begin
                        state_next = FLUSH;
                    end else if (hold_cnt == 4'd0) begin
                        state_next = IDLE;
                    end else begin
                        hold_next = hold_cnt - 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    hold_next  = '0;
                end
            endcase
        end
    end

    // Output merge: reset/exception flush everything, then the sequencer
    // overrides the busy chain for the stages it owns.
    always_comb begin
        stall_v = chain.stall;
        flush_v = chain.flush;
        if (RST || exception_mem) begin
            stall_v = '0;
            flush_v = '1;
        end else begin
            unique case (state)
                FLUSH: begin
                    // F1..EX take bubbles; MEM keeps its busy-chain behaviour.
                    stall_v[ST_EX:ST_F1] = '0;
                    flush_v[ST_EX:ST_F1] = '1;
                end
                HOLD: begin
                    // Freeze fetch until the new vl/vtype has settled.
                    stall_v[ST_F1] = 1'b1;
                    flush_v[ST_F1] = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign hu_if.stall_f1  = stall_v[ST_F1];
    assign hu_if.flush_f1  = flush_v[ST_F1];
    assign hu_if.stall_f2  = stall_v[ST_F2];
    assign hu_if.flush_f2  = flush_v[ST_F2];
    assign hu_if.stall_dec = stall_v[ST_DEC];
    assign hu_if.flush_dec = flush_v[ST_DEC];
    assign hu_if.stall_ex  = stall_v[ST_EX];
    assign hu_if.flush_ex  = flush_v[ST_EX];
    assign hu_if.stall_mem = stall_v[ST_MEM];
    assign hu_if.flush_mem = flush_v[ST_MEM];

`ifdef RV32V_HAZARD_PERF_EN
    rv32v_hazard_perf_cnt #(
        .W (PERF_CNT_W)
    ) u_perf_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (|stall_v),
        .count (stall_cycles)
    );
`endif

endmodule

// File: tb/tb_rv32v_hazard_unit.sv
// Self-checking bench for rv32v_hazard_unit (optionally with RV32V_HAZARD_PERF_EN).
module tb_rv32v_hazard_unit;
    import rv32v_hazard_pkg::*;

    localparam int H      = 2;
    localparam int PERF_W = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    rv32v_hazard_unit_if hif ();
    hazard_state_t dbg_state;
`ifdef RV32V_HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cycles;
`endif

    rv32v_hazard_unit #(
        .CSR_HOLD_CYCLES (H)
`ifdef RV32V_HAZARD_PERF_EN
        ,
        .PERF_CNT_W      (PERF_W)
`endif
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .hu_if         (hif),
        .busy_f1       (hif.busy_f1),
        .busy_f2       (hif.busy_f2),
        .exception_mem (hif.exception_mem),
        .dbg_state     (dbg_state)
`ifdef RV32V_HAZARD_PERF_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // seq = cycles since an accepted CSR update: 0 none, 1 flush cycle, 2..H+1 hold cycles.
    int seq      = 0;
    int perf_exp = 0;

    function automatic logic [9:0] model_ctl(input logic rst, input logic exc,
                                             input logic [4:0] busy, input int sq);
        logic [4:0] st;
        logic [4:0] fl;
        int k;
        st = '0;
        fl = '0;
        k  = -1;
        for (int s = 0; s < 5; s++) if (busy[s]) k = s;
        for (int s = 0; s < 5; s++) if (s <= k) st[s] = 1'b1;
        if (k >= 0 && k < 4) fl[k+1] = 1'b1;
        if (rst || exc) begin
            st = '0;
            fl = '1;
        end else if (sq == 1) begin
            st[3:0] = '0;
            fl[3:0] = '1;
        end else if (sq >= 2) begin
            st[0] = 1'b1;
            fl[0] = 1'b0;
        end
        return {st, fl};
    endfunction

    function automatic int next_seq(input logic rst, input logic exc, input logic csr, input int sq);
        if (rst || exc) return 0;
        if (csr && sq != 1) return 1;
        if (sq >= 1 && sq < H + 1) return sq + 1;
        return 0;
    endfunction

    function automatic int perf_next(input logic rst, input logic [9:0] ctl, input int cur);
        if (rst) return 0;
        if ((ctl[9:5] != 5'd0) && cur < (1 << PERF_W) - 1) return cur + 1;
        return cur;
    endfunction

    function automatic hazard_state_t seq_state(input int sq);
        if (sq == 0) return IDLE;
        if (sq == 1) return FLUSH;
        return HOLD;
    endfunction

    function automatic logic [4:0] cur_busy();
        return {hif.busy_mem, hif.busy_ex, hif.busy_dec, hif.busy_f2, hif.busy_f1};
    endfunction

    function automatic logic [4:0] dut_stall();
        return {hif.stall_mem, hif.stall_ex, hif.stall_dec, hif.stall_f2, hif.stall_f1};
    endfunction

    function automatic logic [4:0] dut_flush();
        return {hif.flush_mem, hif.flush_ex, hif.flush_dec, hif.flush_f2, hif.flush_f1};
    endfunction

    // Advance the model on each edge from the inputs held across that edge.
    always @(posedge CLK) begin
        perf_exp <= perf_next(RST, model_ctl(RST, hif.exception_mem, cur_busy(), seq), perf_exp);
        seq      <= next_seq(RST, hif.exception_mem, hif.csr_update, seq);
    end

    // Compare every cycle, mid-cycle, against the model.
    always @(negedge CLK) begin
        check("model_stall", 32'(dut_stall()),
              32'(model_ctl(RST, hif.exception_mem, cur_busy(), seq) >> 5));
        check("model_flush", 32'(dut_flush()),
              32'(model_ctl(RST, hif.exception_mem, cur_busy(), seq) & 10'h01f));
        check("model_state", 32'(dbg_state), 32'(seq_state(seq)));
`ifdef RV32V_HAZARD_PERF_EN
        check("model_perf", 32'(stall_cycles), 32'(perf_exp));
`endif
    end

    // ---------------- driver ----------------
    task automatic set_in(input logic [4:0] b, input logic csr, input logic exc, input logic rst);
        hif.busy_f1       = b[0];
        hif.busy_f2       = b[1];
        hif.busy_dec      = b[2];
        hif.busy_ex       = b[3];
        hif.busy_mem      = b[4];
        hif.csr_update    = csr;
        hif.exception_mem = exc;
        RST               = rst;
    endtask

    // Apply inputs for one cycle and pin the outputs to hand-computed values.
    task automatic cyc(input logic [4:0] b, input logic csr, input logic exc, input logic rst,
                       input string name, input logic [4:0] e_st, input logic [4:0] e_fl,
                       input hazard_state_t e_s);
        set_in(b, csr, exc, rst);
        @(negedge CLK);
        check({name, "_stall"}, 32'(dut_stall()), 32'(e_st));
        check({name, "_flush"}, 32'(dut_flush()), 32'(e_fl));
        check({name, "_state"}, 32'(dbg_state), 32'(e_s));
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [4:0] rand_busy();
        logic [4:0] b;
        for (int i = 0; i < 5; i++) b[i] = ($urandom_range(0, 9) < 3);
        return b;
    endfunction

    initial begin
        // Reset with random busy: everything flushed, nothing stalled.
        for (int i = 0; i < 3; i++) cyc(rand_busy(), 1'b0, 1'b0, 1'b1, "rst", 5'h00, 5'h1f, IDLE);
        cyc(5'h00, 1'b0, 1'b0, 1'b0, "post_rst", 5'h00, 5'h00, IDLE);

        // EX busy: F1..EX stalled, bubble into MEM.
        for (int i = 0; i < 4; i++) cyc(5'b01000, 1'b0, 1'b0, 1'b0, "busy_ex", 5'b01111, 5'b10000, IDLE);
        cyc(5'h00, 1'b0, 1'b0, 1'b0, "busy_clr", 5'h00, 5'h00, IDLE);

        // CSR update: flush next cycle, then H cycles of F1 hold, then release.
        cyc(5'h00, 1'b1, 1'b0, 1'b0, "csr_req", 5'h00, 5'h00, IDLE);
        cyc(5'h00, 1'b0, 1'b0, 1'b0, "csr_flush", 5'h00, 5'b01111, FLUSH);
        for (int i = 0; i < H; i++) cyc(5'h00, 1'b0, 1'b0, 1'b0, "csr_hold", 5'b00001, 5'h00, HOLD);
        cyc(5'h00, 1'b0, 1'b0, 1'b0, "csr_rel", 5'h00, 5'h00, IDLE);

        // Exception beats a simultaneous CSR update.
        cyc(5'h00, 1'b1, 1'b1, 1'b0, "exc_csr", 5'h00, 5'h1f, IDLE);
        cyc(5'h00, 1'b0, 1'b0, 1'b0, "exc_after", 5'h00, 5'h00, IDLE);

        // CSR update again in the first HOLD cycle restarts the whole sequence.
        cyc(5'h00, 1'b1, 1'b0, 1'b0, "rs_req", 5'h00, 5'h00, IDLE);
        cyc(5'h00, 1'b0, 1'b0, 1'b0, "rs_flush", 5'h00, 5'b01111, FLUSH);
        cyc(5'h00, 1'b1, 1'b0, 1'b0, "rs_hold1", 5'b00001, 5'h00, HOLD);
        cyc(5'h00, 1'b0, 1'b0, 1'b0, "rs_flush2", 5'h00, 5'b01111, FLUSH);
        for (int i = 0; i < H; i++) cyc(5'h00, 1'b0, 1'b0, 1'b0, "rs_hold", 5'b00001, 5'h00, HOLD);
        cyc(5'h00, 1'b0, 1'b0, 1'b0, "rs_rel", 5'h00, 5'h00, IDLE);

        // Busy MEM during FLUSH keeps MEM stalled; busy DEC during HOLD adds to the F1 hold.
        cyc(5'b10000, 1'b1, 1'b0, 1'b0, "mb_req", 5'h1f, 5'h00, IDLE);
        cyc(5'b10000, 1'b0, 1'b0, 1'b0, "mb_flush", 5'b10000, 5'b01111, FLUSH);
        cyc(5'b00100, 1'b0, 1'b0, 1'b0, "db_hold", 5'b00111, 5'b01000, HOLD);
        cyc(5'b00000, 1'b0, 1'b0, 1'b0, "db_hold2", 5'b00001, 5'h00, HOLD);
        cyc(5'b00000, 1'b0, 1'b0, 1'b0, "db_rel", 5'h00, 5'h00, IDLE);

        // Reset mid-sequence abandons it.
        cyc(5'h00, 1'b1, 1'b0, 1'b0, "ra_req", 5'h00, 5'h00, IDLE);
        cyc(5'h00, 1'b0, 1'b0, 1'b1, "ra_rst", 5'h00, 5'h1f, FLUSH);
        cyc(5'h00, 1'b0, 1'b0, 1'b0, "ra_after", 5'h00, 5'h00, IDLE);

`ifdef RV32V_HAZARD_PERF_EN
        // Saturating stall counter: 10 stalled cycles on a 3-bit counter stops at 7.
        cyc(5'h00, 1'b0, 1'b0, 1'b1, "pf_rst", 5'h00, 5'h1f, IDLE);
        set_in(5'h00, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        check("perf_zero", 32'(stall_cycles), 32'd0);
        @(posedge CLK);
        #1;
        for (int i = 0; i < 10; i++) cyc(5'b10000, 1'b0, 1'b0, 1'b0, "pf_busy", 5'h1f, 5'h00, IDLE);
        set_in(5'h00, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        check("perf_sat", 32'(stall_cycles), 32'd7);
        @(posedge CLK);
        #1;
`endif

        // Randomized traffic, checked by the per-cycle model compare.
        for (int i = 0; i < 3000; i++) begin
            set_in(rand_busy(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 29) == 0),
                   ($urandom_range(0, 99) == 0));
            @(posedge CLK);
            #1;
        end

        @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
